// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: receive FSM states, error-flag bit positions, framing and CRC-32 constants.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_t;

  localparam int ERR_CRC   = 0;
  localparam int ERR_RUNT  = 1;
  localparam int ERR_GIANT = 2;
  localparam int ERR_PHY   = 3;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Reflected CRC-32: bytes enter LSB first, so the polynomial is applied bit-reversed.
  function automatic logic [31:0] crc32_step8(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic [31:0] poly_r;
    for (int i = 0; i < 32; i++) poly_r[i] = CRC32_POLY[31-i];
    c = crc;
    for (int i = 0; i < 8; i++) c = (c[0] ^ data[i]) ? ((c >> 1) ^ poly_r) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 update, shared by the receive and transmit paths.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc,
  output logic [31:0] crc_next
);

  always_comb crc_next = crc32_step8(crc, data);

endmodule

// File: rtl/eth_rx_mac.sv
// Byte-wide Ethernet receive framer: preamble/SFD strip, CRC-32 check, FCS removal, runt/giant/PHY flags.
// Optional frame statistics counters are built only when RX_STATS_EN is defined.
//
// state       | meaning
// ST_IDLE     | waiting for rx_dv with a preamble byte or SFD
// ST_PREAMBLE | inside the 0x55 preamble run
// ST_DATA     | post-SFD bytes flowing through the 5-byte FCS delay line
// ST_DROP     | bad preamble or giant frame, ignore until rx_dv falls
module eth_rx_mac
  import eth_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [3:0]  out_err,
  output logic [31:0] stat_good,
  output logic [31:0] stat_bad
);

  localparam logic [10:0] MIN_CNT   = 11'(MIN_LEN);
  localparam logic [10:0] GIANT_CNT = 11'(MAX_LEN + 1);
  localparam logic [10:0] LINE_LEN  = 11'd5;

  rx_state_t   state, state_nxt;
  logic [7:0]  line_q [5];
  logic [10:0] byte_cnt, cnt_inc;
  logic [31:0] crc_q, crc_nxt;
  logic        phy_err_q;
  logic        start, push, emit, emit_last, frame_short;
  logic [3:0]  err_nxt;

  crc32_d8 u_crc (
    .data     (rxd),
    .crc      (crc_q),
    .crc_next (crc_nxt)
  );

  assign cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    push        = 1'b0;
    emit        = 1'b0;
    emit_last   = 1'b0;
    frame_short = 1'b0;
    err_nxt     = '0;
    if (!rx_dv) begin
      state_nxt = ST_IDLE;
      if (state == ST_DATA) begin
        if (byte_cnt >= LINE_LEN) begin
          emit               = 1'b1;
          emit_last          = 1'b1;
          err_nxt[ERR_CRC]   = (crc_q != CRC32_RESIDUE);
          err_nxt[ERR_RUNT]  = (byte_cnt < MIN_CNT);
          err_nxt[ERR_PHY]   = phy_err_q;
        end else begin
          frame_short = 1'b1;
        end
      end
    end else begin
      case (state)
        ST_IDLE, ST_PREAMBLE: begin
          if (rxd == ETH_PREAMBLE) begin
            state_nxt = ST_PREAMBLE;
          end else if (rxd == ETH_SFD) begin
            state_nxt = ST_DATA;
            start     = 1'b1;
          end else begin
            state_nxt = ST_DROP;
          end
        end
        ST_DATA: begin
          push = 1'b1;
          emit = (byte_cnt >= LINE_LEN);
          // Oversized frame: close it out on the oldest byte and discard the rest.
          if (cnt_inc == GIANT_CNT) begin
            emit_last          = 1'b1;
            err_nxt[ERR_CRC]   = 1'b1;
            err_nxt[ERR_GIANT] = 1'b1;
            err_nxt[ERR_PHY]   = phy_err_q | rx_er;
            state_nxt          = ST_DROP;
          end
        end
        default: state_nxt = ST_DROP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_err   <= '0;
      byte_cnt  <= '0;
      crc_q     <= CRC32_INIT;
      phy_err_q <= 1'b0;
      for (int i = 0; i < 5; i++) line_q[i] <= '0;
    end else begin
      out_valid <= emit;
      out_last  <= emit_last;
      out_err   <= err_nxt;
      if (emit) out_data <= line_q[4];
      if (start) begin
        byte_cnt  <= '0;
        crc_q     <= CRC32_INIT;
        phy_err_q <= 1'b0;
      end else if (push) begin
        byte_cnt  <= cnt_inc;
        crc_q     <= crc_nxt;
        phy_err_q <= phy_err_q | rx_er;
        line_q[0] <= rxd;
        for (int i = 1; i < 5; i++) line_q[i] <= line_q[i-1];
      end
    end
  end

`ifdef RX_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_good <= '0;
      stat_bad  <= '0;
    end else if (emit_last) begin
      if (err_nxt == 4'd0) stat_good <= stat_good + 32'd1;
      else                 stat_bad  <= stat_bad + 32'd1;
    end else if (frame_short) begin
      stat_bad <= stat_bad + 32'd1;
    end
  end
`else
  assign stat_good = '0;
  assign stat_bad  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_mac.sv
// Self-checking bench for eth_rx_mac: directed frames plus randomized frames against a frame-level model.
module tb_eth_rx_mac;

  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;
`ifdef RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  out_err;
  logic [31:0] stat_good;
  logic [31:0] stat_bad;

  int checks = 0;
  int errors = 0;
  int exp_good = 0;
  int exp_bad = 0;
  logic [12:0] got [$];
  logic [12:0] exp_q [$];

  always #4 clk = ~clk;

  eth_rx_mac #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .rxd       (rxd),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_err   (out_err),
    .stat_good (stat_good),
    .stat_bad  (stat_bad)
  );

  always @(negedge clk) if (rstn && out_valid) got.push_back({out_data, out_last, out_err});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard Ethernet FCS over the first len bytes (complemented CRC-32).
  function automatic logic [31:0] fcs_of(input bq_t q, input int len);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      logic [7:0] b = q[i];
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ b[0]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
        else                       c = c >> 1;
        b = b >> 1;
      end
    end
    return ~c;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t q = p;
    logic [31:0] f = fcs_of(p, p.size());
    q.push_back(f[7:0]);
    q.push_back(f[15:8]);
    q.push_back(f[23:16]);
    q.push_back(f[31:24]);
    return q;
  endfunction

  // Expected output of one frame that reached the data phase; q is everything after the SFD.
  task automatic model(input bq_t q, input int er);
    int n = q.size();
    int last_i;
    logic [3:0] err = 4'b0000;
    if (n <= 4) begin
      exp_bad++;
      return;
    end
    if (n > MAX_LEN) begin
      last_i = MAX_LEN - 5;
      err = 4'b0101;
      if (er >= 0 && er <= MAX_LEN) err[3] = 1'b1;
    end else begin
      last_i = n - 5;
      if ({q[n-1], q[n-2], q[n-3], q[n-4]} != fcs_of(q, n - 4)) err[0] = 1'b1;
      if (n < MIN_LEN) err[1] = 1'b1;
      if (er >= 0 && er < n) err[3] = 1'b1;
    end
    for (int i = 0; i <= last_i; i++)
      exp_q.push_back({q[i], (i == last_i), (i == last_i) ? err : 4'b0000});
    if (err == 4'b0000) exp_good++;
    else                exp_bad++;
  endtask

  task automatic drive(input logic [7:0] b, input logic e);
    @(negedge clk);
    rx_dv = 1'b1;
    rxd   = b;
    rx_er = e;
  endtask

  task automatic send(input int npre, input logic [7:0] sfd, input bq_t q, input int er);
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b0);
    drive(sfd, 1'b0);
    for (int i = 0; i < q.size(); i++) drive(q[i], (i == er));
    @(negedge clk);
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rxd   = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    int n;
    idle(4);
    chk({tag, "_strobes"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, {19'd0, got[i]}, {19'd0, exp_q[i]});
    chk({tag, "_stat_good"}, stat_good, STATS ? exp_good : 0);
    chk({tag, "_stat_bad"}, stat_bad, STATS ? exp_bad : 0);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    bq_t p, q, q2;
    int lasts;

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    chk("rst_last", {31'd0, out_last}, 0);
    chk("rst_err", {28'd0, out_err}, 0);
    chk("rst_good", stat_good, 0);
    chk("rst_bad", stat_bad, 0);
    rstn = 1'b1;
    idle(2);

    // minimal good frame
    p.delete();
    for (int i = 0; i < 60; i++) p.push_back(8'(i));
    q = with_fcs(p);
    send(7, 8'hD5, q, -1);
    model(q, -1);
    check_all("min_good");

    // one payload bit flipped
    q[20] = q[20] ^ 8'h04;
    send(7, 8'hD5, q, -1);
    model(q, -1);
    check_all("crc_bad");

    // runt with valid FCS
    p.delete();
    for (int i = 0; i < 36; i++) p.push_back(8'($urandom));
    q = with_fcs(p);
    send(7, 8'hD5, q, -1);
    model(q, -1);
    check_all("runt");

    // giant
    q.delete();
    for (int i = 0; i < 1600; i++) q.push_back(8'($urandom));
    send(7, 8'hD5, q, -1);
    model(q, -1);
    check_all("giant");

    // rx_er on payload byte 10 of a good 64-byte frame
    p.delete();
    for (int i = 0; i < 60; i++) p.push_back(8'($urandom));
    q = with_fcs(p);
    send(7, 8'hD5, q, 10);
    model(q, 10);
    check_all("phy_err");

    // corrupted SFD: no output and no count change
    send(7, 8'h5D, q, -1);
    check_all("bad_sfd");

    // frame of 3 bytes
    q.delete();
    q.push_back(8'h01);
    q.push_back(8'h02);
    q.push_back(8'h03);
    send(2, 8'hD5, q, -1);
    model(q, -1);
    check_all("short");

    // back-to-back good frames with a 1-cycle gap
    p.delete();
    for (int i = 0; i < 70; i++) p.push_back(8'($urandom));
    q = with_fcs(p);
    p.delete();
    for (int i = 0; i < 64; i++) p.push_back(8'($urandom));
    q2 = with_fcs(p);
    send(7, 8'hD5, q, -1);
    send(1, 8'hD5, q2, -1);
    model(q, -1);
    model(q2, -1);
    check_all("b2b");

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      int plen = $urandom_range(0, 90);
      int er = -1;
      p.delete();
      for (int i = 0; i < plen; i++) p.push_back(8'($urandom));
      q = with_fcs(p);
      if ($urandom_range(0, 5) == 0) begin
        int keep = $urandom_range(1, 4);
        while (q.size() > keep) void'(q.pop_back());
      end
      if ($urandom_range(0, 3) == 0) begin
        int idx = $urandom_range(0, q.size() - 1);
        q[idx] = q[idx] ^ (8'h01 << $urandom_range(0, 7));
      end
      if ($urandom_range(0, 4) == 0) er = $urandom_range(0, q.size() - 1);
      send($urandom_range(0, 7), 8'hD5, q, er);
      model(q, er);
      check_all("rand");
    end

    // reset in the middle of a frame
    p.delete();
    for (int i = 0; i < 60; i++) p.push_back(8'($urandom));
    q = with_fcs(p);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive(q[i], 1'b0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_data", {24'd0, out_data}, 0);
    chk("midrst_last", {31'd0, out_last}, 0);
    chk("midrst_err", {28'd0, out_err}, 0);
    chk("midrst_good", stat_good, 0);
    chk("midrst_bad", stat_bad, 0);
    lasts = 0;
    foreach (got[i]) if (got[i][4]) lasts++;
    chk("midrst_partial", got.size(), 30 - 5);
    chk("midrst_no_last", lasts, 0);
    got.delete();
    exp_q.delete();
    exp_good = 0;
    exp_bad = 0;
    drive(8'h33, 1'b0);
    drive(8'h44, 1'b0);

    // release with rx_dv high on a non-preamble byte: the rest is dropped
    @(negedge clk);
    rstn  = 1'b1;
    rx_dv = 1'b1;
    rxd   = 8'h12;
    send(7, 8'hD5, q, -1);
    check_all("rel_drop");

    send(7, 8'hD5, q, -1);
    model(q, -1);
    check_all("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_mac.md
# eth_rx_mac

Byte-wide Ethernet receive MAC framer that sits behind the RGMII DDR input capture, on the receive side of the `mac` transmit path. It strips preamble and SFD, checks the FCS with CRC-32, removes the FCS from the stream, and flags runt, giant and PHY-error frames. The output is a non-stallable byte stream with a last-byte marker and per-frame error flags, for the receive buffer feeding the wishbone side.

## Interface
Parameters:
- `MAX_LEN`, default 1518: maximum frame length in bytes, counted from the first byte after the SFD through the FCS.
- `MIN_LEN`, default 64: minimum frame length in bytes, counted the same way.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: receive byte clock (125 MHz); all logic on its rising edge.
- `rstn` in 1: asynchronous active-low reset.
- `rx_dv` in 1: receive data valid from the DDR capture.
- `rx_er` in 1: PHY receive error.
- `rxd` in 8: received byte.
- `out_valid` out 1: `out_data` is valid this cycle.
- `out_data` out 8: payload byte; the FCS is never presented.
- `out_last` out 1: final byte of the frame. Only meaningful when `out_valid` is high.
- `out_err` out 4: error flags, meaningful only when `out_valid && out_last`. Bit 0 CRC, bit 1 runt, bit 2 giant, bit 3 `rx_er`.
- `stat_good` out 32: good-frame count (`RX_STATS_EN` only).
- `stat_bad` out 32: bad-frame count (`RX_STATS_EN` only).

## Operation
- States: IDLE, PREAMBLE, DATA, DROP. Reset state is IDLE.
- IDLE, `rx_dv=1`:
  - `rxd=0x55` → PREAMBLE.
  - `rxd=0xD5` → DATA; a short preamble is accepted.
  - any other byte → DROP.
- PREAMBLE:
  - `0x55` → stay.
  - `0xD5` → DATA.
  - any other byte → DROP.
- Any state, `rx_dv=0` → IDLE in the same cycle. Back-to-back frames with a 1-cycle gap are supported.
- DATA:
  - Each byte is pushed into a 5-entry delay line, feeds the CRC, and increments an 11-bit byte counter that saturates at 2047.
  - Once the line holds 5 bytes, every further push emits the oldest entry with `out_valid=1` and `out_last=0`.
- End of frame (first `rx_dv=0` in DATA):
  - If at least 5 bytes were received, the oldest entry is emitted with `out_last=1` and the flags on `out_err`.
  - The remaining 4 entries are the FCS and are discarded.
  - With 4 or fewer bytes, nothing is emitted and the frame counts as bad.
- CRC:
  - Reflected CRC-32, polynomial 0x04C11DB7, initial value 0xFFFFFFFF.
  - Covers every byte after the SFD, including the FCS.
  - Frame is good when the register equals 0xDEBB20E3 (no final inversion). Otherwise bit 0 is set.
- Runt: bit 1 set when the byte count is below `MIN_LEN`.
- `rx_er`: bit 3 is a sticky flag, set if `rx_er=1` on any DATA cycle.
- Giant:
  - On the push that takes the count to `MAX_LEN+1`, the oldest entry is emitted with `out_last=1` and bit 2 set; bit 0 is also set.
  - The state then goes to DROP, which ignores input until `rx_dv=0`.
- DROP emits nothing.
- Reset:
  - All outputs go to 0, the delay line is cleared and the state is IDLE.
  - A frame in progress is lost with no `out_last`.
  - If `rx_dv` is high when reset releases, a byte other than 0x55/0xD5 sends the block to DROP.

## Timing
- Output registers update on the rising edge of `clk`.
- Payload byte k appears the cycle after the edge that samples payload byte k+5.
- The last payload byte appears the cycle after the first edge that samples `rx_dv=0`.
- `out_valid` is a single-cycle strobe per byte. There is no backpressure; the consumer must accept every byte.
- `stat_good` or `stat_bad` increments in the same cycle `out_last` is emitted, or for a frame of 4 or fewer bytes, the cycle after `rx_dv` falls.
- Both counters wrap at 2^32.

## Configuration
- `RX_STATS_EN` defined: `stat_good` and `stat_bad` are implemented.
  - A frame is good when `out_err == 0`.
  - DROP entries caused by a bad preamble or SFD are not counted.
- `RX_STATS_EN` undefined:
  - Both ports are tied to 0.
  - No counter flops are generated.

## Structure
- Shared package `eth_pkg`:
  - State enum.
  - `out_err` bit indices.
  - Constants `ETH_PREAMBLE=8'h55`, `ETH_SFD=8'hD5`, `CRC32_POLY`, `CRC32_INIT`, `CRC32_RESIDUE`.
- Sub-module `crc32_d8`:
  - Combinational next-CRC from an 8-bit data input and a 32-bit current value.
  - Also usable by the transmit path.

## Test plan
- Minimal good frame: 7×0x55, 0xD5, 60 bytes 0x00..0x3B, then a valid FCS → 60 strobes carrying 0x00..0x3B. `out_last` on 0x3B, `out_err=0`, `stat_good=1`.
- Same frame with one payload bit flipped → 60 strobes, `out_err=4'b0001`, `stat_bad=1`.
- 40-byte frame with a valid FCS → 36 strobes, `out_err=4'b0010`.
- 1600-byte frame → exactly 1514 strobes. The last one has `out_err` bits 2 and 0 set; the rest of the input produces no output.
- `rx_er` pulsed on payload byte 10 of a good 64-byte frame → `out_err=4'b1000`. Separately, SFD replaced by 0x5D → no output and no count change.
- Two good frames with a 1-cycle IFG → both delivered intact. Then `rstn` asserted mid-frame → all outputs 0 immediately, with no `out_last` for that frame.
